// File: rtl/titan_pipeline_ctrl_if.sv
// Hazard/forwarding bundle between the pipeline datapath and titan_pipeline_ctrl.
// The datapath drives stage state (master); the controller returns selects and stage controls (slave).
interface titan_pipeline_ctrl_if;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic [4:0]  ex_waddr_i;
    logic        ex_we_i;
    logic        ex_load_i;
    logic [4:0]  mem_waddr_i;
    logic        mem_we_i;
    logic [4:0]  wb_waddr_i;
    logic        wb_we_i;
    logic        take_branch_i;
    logic        take_jump_i;
    logic        dmem_busy_i;
    logic        trap_i;
    logic [1:0]  forward_a_sel_o;
    logic [1:0]  forward_b_sel_o;
    logic        pc_stall_o;
    logic        if_stall_o;
    logic        if_flush_o;
    logic        id_stall_o;
    logic        id_flush_o;
    logic        ex_stall_o;
    logic        ex_flush_o;
    logic        mem_stall_o;
    logic        mem_flush_o;
    logic        pc_redirect_o;
    logic [31:0] perf_stall_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, ex_waddr_i, ex_we_i, ex_load_i,
               mem_waddr_i, mem_we_i, wb_waddr_i, wb_we_i,
               take_branch_i, take_jump_i, dmem_busy_i, trap_i,
        input  forward_a_sel_o, forward_b_sel_o, pc_stall_o,
               if_stall_o, if_flush_o, id_stall_o, id_flush_o,
               ex_stall_o, ex_flush_o, mem_stall_o, mem_flush_o,
               pc_redirect_o, perf_stall_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, ex_waddr_i, ex_we_i, ex_load_i,
               mem_waddr_i, mem_we_i, wb_waddr_i, wb_we_i,
               take_branch_i, take_jump_i, dmem_busy_i, trap_i,
        output forward_a_sel_o, forward_b_sel_o, pc_stall_o,
               if_stall_o, if_flush_o, id_stall_o, id_flush_o,
               ex_stall_o, ex_flush_o, mem_stall_o, mem_flush_o,
               pc_redirect_o, perf_stall_cnt_o
    );
endinterface

// File: rtl/titan_pipeline_ctrl.sv
// Five-stage pipeline hazard controller: operand forwarding selects, stall/flush/redirect
// sequencing for trap, data-memory wait, load-use and taken control flow, plus a stall counter.
module titan_pipeline_ctrl (
    input  logic               clk_i,
    input  logic               rst_i,
    titan_pipeline_ctrl_if.slave ctrl
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_TRAP     = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] perf_cnt_r;
    logic        hazard_s;
    logic        load_use_s;
    logic        cflow_s;
    logic        pc_stall_s;
    logic        if_stall_s;
    logic        id_stall_s;
    logic        ex_stall_s;
    logic        mem_stall_s;
    logic        if_flush_s;
    logic        id_flush_s;
    logic        ex_flush_s;
    logic        mem_flush_s;
    logic        redirect_s;

    // Youngest producer wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       ex_we,  input logic [4:0] ex_wa,
        input logic       mem_we, input logic [4:0] mem_wa,
        input logic       wb_we,  input logic [4:0] wb_wa
    );
        logic [1:0] sel;
        if (rs == 5'd0)                     sel = 2'd0;
        else if (ex_we  && (ex_wa  == rs))  sel = 2'd1;
        else if (mem_we && (mem_wa == rs))  sel = 2'd2;
        else if (wb_we  && (wb_wa  == rs))  sel = 2'd3;
        else                                sel = 2'd0;
        return sel;
    endfunction

    assign ctrl.forward_a_sel_o = fwd_sel(ctrl.id_rs1_i, ctrl.ex_we_i, ctrl.ex_waddr_i,
                                          ctrl.mem_we_i, ctrl.mem_waddr_i,
                                          ctrl.wb_we_i, ctrl.wb_waddr_i);
    assign ctrl.forward_b_sel_o = fwd_sel(ctrl.id_rs2_i, ctrl.ex_we_i, ctrl.ex_waddr_i,
                                          ctrl.mem_we_i, ctrl.mem_waddr_i,
                                          ctrl.wb_we_i, ctrl.wb_waddr_i);

    assign hazard_s   = ctrl.ex_load_i && ctrl.ex_we_i && (ctrl.ex_waddr_i != 5'd0) &&
                        ((ctrl.ex_waddr_i == ctrl.id_rs1_i) || (ctrl.ex_waddr_i == ctrl.id_rs2_i));
    // The instruction just stalled behind the load is allowed through on the following cycle.
    assign load_use_s = hazard_s && (state_r != ST_LD_STALL);
    assign cflow_s    = ctrl.take_branch_i || ctrl.take_jump_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection, trap > memory wait > load-use > control flow.
    always_comb begin
        state_nxt_s = ST_RUN;
        if (ctrl.trap_i) begin
            state_nxt_s = ST_TRAP;
        end else if (ctrl.dmem_busy_i) begin
            state_nxt_s = ST_MEM_WAIT;
        end else begin
            case (state_r)
                ST_TRAP:     state_nxt_s = ST_RUN;
                ST_RUN,
                ST_LD_STALL,
                ST_MEM_WAIT: state_nxt_s = load_use_s ? ST_LD_STALL : ST_RUN;
                default:     state_nxt_s = ST_RUN;
            endcase
        end
    end

    // Mealy stage controls; reset holds every stage in flush.
    always_comb begin
        pc_stall_s  = 1'b0;
        if_stall_s  = 1'b0;
        id_stall_s  = 1'b0;
        ex_stall_s  = 1'b0;
        mem_stall_s = 1'b0;
        if_flush_s  = 1'b0;
        id_flush_s  = 1'b0;
        ex_flush_s  = 1'b0;
        mem_flush_s = 1'b0;
        redirect_s  = 1'b0;
        if (!rst_i) begin
            if_flush_s  = 1'b1;
            id_flush_s  = 1'b1;
            ex_flush_s  = 1'b1;
            mem_flush_s = 1'b1;
        end else if (ctrl.trap_i) begin
            if_flush_s  = 1'b1;
            id_flush_s  = 1'b1;
            ex_flush_s  = 1'b1;
            mem_flush_s = 1'b1;
        end else if (ctrl.dmem_busy_i) begin
            pc_stall_s  = 1'b1;
            if_stall_s  = 1'b1;
            id_stall_s  = 1'b1;
            ex_stall_s  = 1'b1;
            mem_stall_s = 1'b1;
        end else begin
            case (state_r)
                // Front end still holds wrong-path instructions from before the trap.
                ST_TRAP: begin
                    if_flush_s = 1'b1;
                    id_flush_s = 1'b1;
                end
                ST_RUN,
                ST_LD_STALL,
                ST_MEM_WAIT: begin
                    if (load_use_s) begin
                        pc_stall_s = 1'b1;
                        if_stall_s = 1'b1;
                        id_flush_s = 1'b1;
                    end else if (cflow_s) begin
                        redirect_s = 1'b1;
                        if_flush_s = 1'b1;
                    end else begin
                        redirect_s = 1'b0;
                    end
                end
                default: begin
                    redirect_s = 1'b0;
                end
            endcase
        end
    end

    // Saturating count of PC-stall cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_cnt_r <= 32'd0;
        end else if (pc_stall_s && (perf_cnt_r != 32'hFFFF_FFFF)) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign ctrl.pc_stall_o       = pc_stall_s;
    assign ctrl.if_stall_o       = if_stall_s;
    assign ctrl.id_stall_o       = id_stall_s;
    assign ctrl.ex_stall_o       = ex_stall_s;
    assign ctrl.mem_stall_o      = mem_stall_s;
    assign ctrl.if_flush_o       = if_flush_s;
    assign ctrl.id_flush_o       = id_flush_s;
    assign ctrl.ex_flush_o       = ex_flush_s;
    assign ctrl.mem_flush_o      = mem_flush_s;
    assign ctrl.pc_redirect_o    = redirect_s;
    assign ctrl.perf_stall_cnt_o = perf_cnt_r;

endmodule

// File: tb/tb_titan_pipeline_ctrl.sv
// Directed bench for titan_pipeline_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_titan_pipeline_ctrl;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] exw;
        logic       exwe;
        logic       exld;
        logic [4:0] memw;
        logic       memwe;
        logic [4:0] wbw;
        logic       wbwe;
        logic       br;
        logic       jmp;
        logic       busy;
        logic       trap;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [9:0] ctl;
    } vec_t;

    // ctl = {pc_stall, if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush, redirect}
    localparam logic [9:0] C_NONE  = 10'b00000_0000_0;
    localparam logic [9:0] C_BUSY  = 10'b11111_0000_0;
    localparam logic [9:0] C_FLUSH = 10'b00000_1111_0;
    localparam logic [9:0] C_BR    = 10'b00000_1000_1;
    localparam logic [9:0] C_LU    = 10'b11000_0100_0;
    localparam logic [9:0] C_TRAPS = 10'b00000_1100_0;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t vecs [16];
    vec_t idle_v;
    vec_t v;

    titan_pipeline_ctrl_if bus ();

    titan_pipeline_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ctl_now();
        return {bus.pc_stall_o, bus.if_stall_o, bus.id_stall_o, bus.ex_stall_o, bus.mem_stall_o,
                bus.if_flush_o, bus.id_flush_o, bus.ex_flush_o, bus.mem_flush_o, bus.pc_redirect_o};
    endfunction

    task automatic drive(input vec_t d);
        bus.id_rs1_i      = d.rs1;
        bus.id_rs2_i      = d.rs2;
        bus.ex_waddr_i    = d.exw;
        bus.ex_we_i       = d.exwe;
        bus.ex_load_i     = d.exld;
        bus.mem_waddr_i   = d.memw;
        bus.mem_we_i      = d.memwe;
        bus.wb_waddr_i    = d.wbw;
        bus.wb_we_i       = d.wbwe;
        bus.take_branch_i = d.br;
        bus.take_jump_i   = d.jmp;
        bus.dmem_busy_i   = d.busy;
        bus.trap_i        = d.trap;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive at the falling edge, compare controls 1 time unit later.
    task automatic step_chk(input string nm, input vec_t d, input logic [9:0] exp);
        @(negedge clk);
        drive(d);
        #1;
        chk(nm, {22'd0, ctl_now()}, {22'd0, exp});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_v = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, C_NONE};
        //          rs1    rs2    exw    we    ld    memw   mwe   wbw    wwe   br    jmp   busy  trap  fa    fb    ctl
        vecs[0]  = '{5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, C_NONE};
        vecs[1]  = '{5'd5, 5'd0,  5'd5,  1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, C_NONE};
        vecs[2]  = '{5'd5, 5'd0,  5'd5,  1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, C_NONE};
        vecs[3]  = '{5'd9, 5'd9,  5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3, C_NONE};
        vecs[4]  = '{5'd0, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, C_NONE};
        vecs[5]  = '{5'd4, 5'd3,  5'd4,  1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, C_NONE};
        vecs[6]  = '{5'd6, 5'd6,  5'd6,  1'b0, 1'b0, 5'd6, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, C_NONE};
        vecs[7]  = '{5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, C_BR};
        vecs[8]  = '{5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, C_BR};
        vecs[9]  = '{5'd7, 5'd0,  5'd7,  1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, C_LU};
        vecs[10] = '{5'd7, 5'd0,  5'd7,  1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, C_NONE};
        vecs[11] = '{5'd0, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, C_NONE};
        vecs[12] = '{5'd2, 5'd0,  5'd0,  1'b0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, C_BUSY};
        vecs[13] = '{5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, C_FLUSH};
        vecs[14] = '{5'd0, 5'd12, 5'd12, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, C_LU};
        vecs[15] = '{5'd8, 5'd0,  5'd8,  1'b1, 1'b0, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, C_NONE};

        // Reset behaviour, with forwarding still live and events on the inputs.
        rst = 1'b0;
        v = vecs[1];
        v.busy = 1'b1;
        drive(v);
        #1;
        chk("rst_ctl", {22'd0, ctl_now()}, {22'd0, C_FLUSH});
        chk("rst_fwd_a", {30'd0, bus.forward_a_sel_o}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", bus.perf_stall_cnt_o, 32'd0);
        @(negedge clk);
        drive(idle_v);
        rst = 1'b1;

        // Single-cycle table from RUN; idle cycles return the FSM to RUN afterwards.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_fa", i), {30'd0, bus.forward_a_sel_o}, {30'd0, vecs[i].fa});
            chk($sformatf("vec%0d_fb", i), {30'd0, bus.forward_b_sel_o}, {30'd0, vecs[i].fb});
            chk($sformatf("vec%0d_ctl", i), {22'd0, ctl_now()}, {22'd0, vecs[i].ctl});
            @(negedge clk);
            drive(idle_v);
            @(negedge clk);
        end

        // Fresh counter for the sequences.
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;

        // Load-use with a taken branch: stall first, branch honoured in LD_STALL.
        v = idle_v;
        v.exld = 1'b1; v.exwe = 1'b1; v.exw = 5'd7; v.rs2 = 5'd7; v.br = 1'b1;
        step_chk("lu_c0", v, C_LU);
        step_chk("lu_c1", v, C_BR);
        step_chk("lu_c2", idle_v, C_NONE);
        chk("lu_cnt", bus.perf_stall_cnt_o, 32'd1);

        // Three busy cycles hide a pending jump.
        v = idle_v;
        v.busy = 1'b1; v.jmp = 1'b1;
        for (int i = 0; i < 3; i++) step_chk($sformatf("busy_c%0d", i), v, C_BUSY);
        step_chk("busy_exit", idle_v, C_NONE);
        chk("busy_cnt", bus.perf_stall_cnt_o, 32'd4);
        step_chk("busy_run", idle_v, C_NONE);

        // Trap while waiting on memory.
        v = idle_v;
        v.busy = 1'b1;
        step_chk("mw_enter", v, C_BUSY);
        v.trap = 1'b1;
        step_chk("trap_c0", v, C_FLUSH);
        step_chk("trap_c1", idle_v, C_TRAPS);
        step_chk("trap_c2", idle_v, C_NONE);
        chk("trap_cnt", bus.perf_stall_cnt_o, 32'd5);

        // Saturation from a preset value.
        @(negedge clk);
        force dut.perf_cnt_r = 32'hFFFF_FFFD;
        #1;
        release dut.perf_cnt_r;
        v = idle_v;
        v.busy = 1'b1;
        step_chk("sat_c0", v, C_BUSY);
        step_chk("sat_c1", v, C_BUSY);
        chk("sat_cnt_fe", bus.perf_stall_cnt_o, 32'hFFFF_FFFE);
        step_chk("sat_c2", v, C_BUSY);
        step_chk("sat_c3", v, C_BUSY);
        chk("sat_cnt_ff", bus.perf_stall_cnt_o, 32'hFFFF_FFFF);
        step_chk("sat_c4", idle_v, C_NONE);
        chk("sat_hold", bus.perf_stall_cnt_o, 32'hFFFF_FFFF);

        // Reset in MEM_WAIT.
        step_chk("rmw_c0", v, C_BUSY);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rmw_ctl", {22'd0, ctl_now()}, {22'd0, C_FLUSH});
        chk("rmw_cnt", bus.perf_stall_cnt_o, 32'd0);
        @(negedge clk);
        drive(idle_v);
        rst = 1'b1;
        #1;
        chk("rmw_rel", {22'd0, ctl_now()}, {22'd0, C_NONE});
        step_chk("rmw_run", idle_v, C_NONE);
        chk("rmw_cnt2", bus.perf_stall_cnt_o, 32'd0);

        // Reset in TRAP: afterwards no residual front-end flush.
        v = idle_v;
        v.trap = 1'b1;
        step_chk("rtr_c0", v, C_FLUSH);
        @(negedge clk);
        drive(idle_v);
        rst = 1'b0;
        #1;
        chk("rtr_ctl", {22'd0, ctl_now()}, {22'd0, C_FLUSH});
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rtr_rel", {22'd0, ctl_now()}, {22'd0, C_NONE});

        // Reset in LD_STALL: load-use detection must be live again.
        v = idle_v;
        v.exld = 1'b1; v.exwe = 1'b1; v.exw = 5'd3; v.rs1 = 5'd3;
        step_chk("rld_c0", v, C_LU);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rld_ctl", {22'd0, ctl_now()}, {22'd0, C_FLUSH});
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rld_rel", {22'd0, ctl_now()}, {22'd0, C_LU});
        step_chk("rld_end", idle_v, C_NONE);
        step_chk("rld_run", idle_v, C_NONE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/titan_pipeline_ctrl.md
TITAN_PIPELINE_CTRL -- requirements
Module: titan_pipeline_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_i  in  1  clock; all state on rising edge.
REQ-003 rst_i  in  1  asynchronous active-low reset.
REQ-004 id_rs1_i, id_rs2_i  in  5 each  source registers of the instruction in ID.
REQ-005 ex_waddr_i, ex_we_i, ex_load_i  in  5/1/1  EX destination, write enable, EX holds a load.
REQ-006 mem_waddr_i, mem_we_i  in  5/1  MEM destination, write enable.
REQ-007 wb_waddr_i, wb_we_i  in  5/1  WB destination, write enable.
REQ-008 take_branch_i, take_jump_i  in  1/1  branch or jump resolved taken in ID.
REQ-009 dmem_busy_i  in  1  data memory has not completed the MEM-stage access.
REQ-010 trap_i  in  1  exception or xret committed in MEM.
REQ-011 forward_a_sel_o, forward_b_sel_o  out  2 each  forwarding select: 0 regfile, 1 EX, 2 MEM, 3 WB.
REQ-012 pc_stall_o  out  1  hold PC.
REQ-013 if_stall_o/if_flush_o, id_stall_o/id_flush_o, ex_stall_o/ex_flush_o  out  1 each  hold/bubble the IF/ID, ID/EX and EX/MEM registers.
REQ-014 mem_stall_o/mem_flush_o  out  1 each  hold/bubble the MEM/WB register.
REQ-015 pc_redirect_o  out  1  PC SHALL load the branch/jump target this cycle.
REQ-016 perf_stall_cnt_o  out  32  count of cycles with pc_stall_o high.

Function
REQ-017 Forwarding SHALL be combinational per source rs: 0 if rs==0; else 1 if ex_we_i & ex_waddr_i==rs; else 2 if mem_we_i & mem_waddr_i==rs; else 3 if wb_we_i & wb_waddr_i==rs; else 0.
REQ-018 The load-use hazard is defined as ex_load_i & ex_we_i & ex_waddr_i!=0 & (ex_waddr_i==id_rs1_i | ex_waddr_i==id_rs2_i).
REQ-019 FSM states SHALL be RUN, LD_STALL, MEM_WAIT and TRAP; outputs are Mealy (same-cycle).
REQ-020 Event priority SHALL be trap_i > dmem_busy_i > load-use > branch/jump, evaluated in every state.
REQ-021 trap_i: assert if_flush_o, id_flush_o, ex_flush_o and mem_flush_o; all stalls low; pc_redirect_o low; next state TRAP.
REQ-022 TRAP SHALL assert if_flush_o and id_flush_o for exactly one cycle and then go to RUN, unless trap_i is high again.
REQ-023 dmem_busy_i: assert pc_stall_o and every *_stall_o; assert no flush; next state MEM_WAIT; MEM_WAIT SHALL go to RUN in the cycle after dmem_busy_i falls.
REQ-024 Load-use in RUN: assert pc_stall_o and if_stall_o, assert id_flush_o, hold pc_redirect_o low; next state LD_STALL.
REQ-025 LD_STALL SHALL mask load-use detection for one cycle, otherwise behave as RUN, then go to RUN.
REQ-026 Branch/jump with no higher-priority event: pc_redirect_o=1 and if_flush_o=1, no stalls.
REQ-027 In RUN with no event, all stall, flush and redirect outputs SHALL be 0.
REQ-028 perf_stall_cnt_o SHALL increment by 1 on each cycle with pc_stall_o=1 and saturate at 32'hFFFF_FFFF.

Reset
REQ-029 While rst_i=0: state RUN, perf_stall_cnt_o=0, all *_flush_o=1, all stalls 0, pc_redirect_o=0.
REQ-030 Forwarding selects SHALL remain purely combinational and unaffected by reset.
REQ-031 Reset asserted mid-MEM_WAIT, mid-LD_STALL or mid-TRAP SHALL return to RUN immediately and keep the counter at 0.

Verification
REQ-032 ex_we=1, ex_waddr=5, mem_we=1, mem_waddr=5, id_rs1=5, id_rs2=0 -> fwd_a=1, fwd_b=0; with ex_we=0 -> fwd_a=2.
REQ-033 ex_load=1, ex_waddr=7, id_rs2=7, take_branch=1 -> cycle0: pc_stall=if_stall=id_flush=1, redirect=0; cycle1 (LD_STALL): redirect=1, if_flush=1; cycle2 RUN.
REQ-034 dmem_busy high 3 cycles together with take_jump -> all stalls high 3 cycles, redirect 0, no flushes; perf_stall_cnt +3.
REQ-035 trap_i pulse during MEM_WAIT -> that cycle: all four flushes, no stalls; next cycle: if_flush=id_flush=1 only; then RUN.
REQ-036 Counter preset near saturation (drive 0xFFFF_FFFE stall cycles or force state), 3 stall cycles -> holds at 0xFFFF_FFFF.
REQ-037 rst_i low during MEM_WAIT -> flushes 1 and stalls 0 immediately, counter 0; after release with no events -> all controls 0.
